controle_jogo: RTL
==================

// Module: controle_jogo
//
// PURPOSE
//   Game-control stage downstream of the parity/comparator hint block. It
//   turns the pushbutton "confirm" into a single-cycle event and samples the
//   comparator result on that event. It sequences the game: guess senha A,
//   then senha B, then win or lose. It also drives modoB back to the
//   comparator and latches the hint shown on HEX6.
//
// PARAMETERS
//   MAX_TENT  8  total attempts allowed over both phases (legal range 1..15)
//
// PORTS
//   clk         in   1  system clock
//   rst         in   1  asynchronous reset, active-high
//   confirma    in   1  raw confirm button level, active-high, asynchronous to clk
//   reiniciar   in   1  synchronous restart request, level, active-high
//   comp        in   2  comparator result: 00 less, 01 greater, 10 equal, 11 invalid
//   modoB       out  1  0 = comparing senha A, 1 = comparing senha B
//   dica        out  2  comp value latched at the last accepted attempt
//   dica_valida out  1  1 once at least one attempt has been accepted in this game
//   tentativas  out  4  attempts used so far
//   restantes   out  4  MAX_TENT - tentativas (combinational from the register)
//   vitoria     out  1  1 in state VITORIA
//   derrota     out  1  1 in state DERROTA
//
// BEHAVIOUR
//   - Reset (async, rst=1):
//       state = SENHA_A
//       modoB = 0, dica = 00, dica_valida = 0, tentativas = 0
//       vitoria = 0, derrota = 0, all synchronizer flops = 0
//       restantes therefore = MAX_TENT
//   - Confirm path:
//       confirma goes through 2-flop synchronizer s1 -> s2, then a history flop s3.
//       ev = s2 & ~s3 (rising edge), one cycle wide.
//       A held button gives exactly one ev; ev does not repeat until release.
//       Latency: registered outputs update on the 3rd rising clk edge after
//       confirma rises.
//   - FSM states: SENHA_A (modoB=0), SENHA_B (modoB=1), VITORIA, DERROTA.
//     modoB, vitoria and derrota are decoded from the state register.
//   - On ev in SENHA_A or SENHA_B, when comp != 11 (accepted attempt):
//       tentativas <= tentativas + 1
//       dica <= comp, dica_valida <= 1
//       comp == 10 in SENHA_A -> SENHA_B
//       comp == 10 in SENHA_B -> VITORIA
//       comp != 10 and tentativas+1 == MAX_TENT -> DERROTA
//       otherwise stay in the current state
//   - A correct guess on the last allowed attempt wins over exhaustion:
//       SENHA_B -> VITORIA, SENHA_A -> SENHA_B.
//     In SENHA_B with tentativas == MAX_TENT, the next miss -> DERROTA.
//     tentativas saturates at MAX_TENT and never wraps.
//   - On ev with comp == 11: ignored. No count, no dica update, no state change.
//   - In VITORIA and DERROTA, ev is ignored and all outputs hold.
//   - reiniciar = 1 at a clk edge, in any state:
//       state = SENHA_A, tentativas = 0, dica = 00, dica_valida = 0
//       reiniciar overrides a simultaneous ev.
//       Synchronizer flops are not cleared.
//   - rst asserted mid-game returns all outputs to reset values immediately,
//     without waiting for a clock.
//   - dica and tentativas change only on accepted attempts or restart.
//     comp changing between events has no effect.
//
// TESTING
//   1. Reset: rst pulse -> modoB=0, tentativas=0, restantes=MAX_TENT,
//      dica_valida=0, vitoria=0, derrota=0.
//   2. Edge detect: confirma held 20 cycles with comp=00 -> tentativas=1 exactly,
//      updated on 3rd edge after the rise; dica=00, dica_valida=1.
//   3. Happy path: ev with comp=01, ev with comp=10 (modoB -> 1),
//      ev with comp=10 -> vitoria=1, tentativas=3, restantes=5.
//   4. Exhaustion: 8 ev with comp=00 -> derrota=1 after the 8th, tentativas=8.
//      A 9th ev changes nothing.
//      Variant: 7 misses then comp=10 -> SENHA_B, tentativas=8;
//      then a miss -> derrota=1.
//   5. Invalid and restart: ev with comp=11 -> no change. reiniciar together
//      with ev in SENHA_B -> SENHA_A, tentativas=0, dica_valida=0.
//   6. Async reset: rst asserted mid-cycle in SENHA_B -> modoB=0 before the
//      next clk edge.

Source files
------------

// File: rtl/controle_jogo.sv
// -----------------------------------------------------------------------------
// controle_jogo
//   Game-control stage that sits after the comparator hint block.
//   - Synchronizes the raw "confirm" button and turns each press into a single
//     one-cycle event.
//   - On each event, samples the comparator result and sequences the game:
//     guess senha A, then senha B, then win or lose.
//   - Drives modoB back to the comparator and latches the last hint.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   confirma     in   raw confirm button level (asynchronous to clk)
//   reiniciar    in   synchronous restart request, level, active-high
//   comp[1:0]    in   comparator result: 00 less, 01 greater, 10 equal, 11 invalid
//   modoB        out  0 = comparing senha A, 1 = comparing senha B
//   dica[1:0]    out  comp value latched at the last accepted attempt
//   dica_valida  out  1 once an attempt has been accepted in this game
//   tentativas   out  attempts used so far
//   restantes    out  MAX_TENT - tentativas
//   vitoria      out  game won
//   derrota      out  game lost
// -----------------------------------------------------------------------------
module controle_jogo #(
  parameter int MAX_TENT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirma,
  input  logic       reiniciar,
  input  logic [1:0] comp,
  output logic       modoB,
  output logic [1:0] dica,
  output logic       dica_valida,
  output logic [3:0] tentativas,
  output logic [3:0] restantes,
  output logic       vitoria,
  output logic       derrota
);

  localparam logic [3:0] MAX_T = 4'(MAX_TENT);

  localparam logic [1:0] COMP_IGUAL    = 2'b10;
  localparam logic [1:0] COMP_INVALIDO = 2'b11;

  typedef enum logic [1:0] {
    SENHA_A = 2'd0,
    SENHA_B = 2'd1,
    VITORIA = 2'd2,
    DERROTA = 2'd3
  } estado_t;

  estado_t     estado_r;
  estado_t     proxEstado_s;
  logic [3:0]  tentativas_r;
  logic [3:0]  proxTent_s;
  logic [1:0]  dica_r;
  logic        dicaValida_r;
  logic        aceito_s;

  logic        s1_r;
  logic        s2_r;
  logic        s3_r;
  logic        ev_s;

  // Two-flop synchronizer plus history flop for the confirm button.
  // Restart does not touch these, so a button held across a restart
  // cannot generate a second event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= confirma;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Rising edge of the synchronized button: one cycle per press.
  assign ev_s = s2_r & ~s3_r;

  // Next-state and counter decode for an accepted attempt.
  always_comb begin
    aceito_s     = 1'b0;
    proxEstado_s = estado_r;
    proxTent_s   = tentativas_r;
    if (ev_s && (estado_r == SENHA_A || estado_r == SENHA_B) && comp != COMP_INVALIDO) begin
      aceito_s = 1'b1;
      // Saturate: a win on the last attempt in SENHA_A leaves the count at
      // MAX_TENT while the game continues in SENHA_B.
      if (tentativas_r >= MAX_T) begin
        proxTent_s = MAX_T;
      end else begin
        proxTent_s = tentativas_r + 4'd1;
      end
      case (estado_r)
        SENHA_A: begin
          if (comp == COMP_IGUAL) begin
            proxEstado_s = SENHA_B;
          end else if (tentativas_r >= MAX_T - 4'd1) begin
            proxEstado_s = DERROTA;
          end else begin
            proxEstado_s = SENHA_A;
          end
        end
        SENHA_B: begin
          if (comp == COMP_IGUAL) begin
            proxEstado_s = VITORIA;
          end else if (tentativas_r >= MAX_T - 4'd1) begin
            proxEstado_s = DERROTA;
          end else begin
            proxEstado_s = SENHA_B;
          end
        end
        default: begin
          proxEstado_s = estado_r;
        end
      endcase
    end else begin
      aceito_s = 1'b0;
    end
  end

  // Game state, attempt counter and latched hint. Restart wins over a
  // simultaneous event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r     <= SENHA_A;
      tentativas_r <= 4'd0;
      dica_r       <= 2'b00;
      dicaValida_r <= 1'b0;
    end else if (reiniciar) begin
      estado_r     <= SENHA_A;
      tentativas_r <= 4'd0;
      dica_r       <= 2'b00;
      dicaValida_r <= 1'b0;
    end else if (aceito_s) begin
      estado_r     <= proxEstado_s;
      tentativas_r <= proxTent_s;
      dica_r       <= comp;
      dicaValida_r <= 1'b1;
    end else begin
      estado_r     <= estado_r;
      tentativas_r <= tentativas_r;
      dica_r       <= dica_r;
      dicaValida_r <= dicaValida_r;
    end
  end

  // Outputs decoded directly from registers (no input-to-output paths).
  assign modoB       = (estado_r == SENHA_B);
  assign vitoria     = (estado_r == VITORIA);
  assign derrota     = (estado_r == DERROTA);
  assign dica        = dica_r;
  assign dica_valida = dicaValida_r;
  assign tentativas  = tentativas_r;
  assign restantes   = MAX_T - tentativas_r;

endmodule
